// File: rtl/decoder_2x4_str.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decoder_2x4_str                                               |
// | Purpose  : 2-to-4 line decoder with active-high enable. It is built from |
// |            NOT/AND gate primitives and has a registered output stage     |
// |            that gives a glitch-free chip-select bus.                     |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst    - synchronous active-high reset                        |
// |            a      - select MSB                                           |
// |            b      - select LSB                                           |
// |            en     - decode enable, active high                           |
// |            z      - [0:3] registered select bus; {a,b}=00 selects z[0]   |
// |            vld    - registered copy of en                                |
// |            z_comb - [0:3] unregistered decode     (optional feature)     |
// |            err    - registered one-hot violation  (optional feature)     |
// | Params   : OUT_ACT_LOW - 1 gives active-low selects, with reset to 1111  |
// | Macro    : DECODER_2X4_STR_COMB_OUT_EN adds the z_comb and err ports     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module decoder_2x4_str #(
  parameter bit OUT_ACT_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic [0:3] z,
  output logic       vld
`ifdef DECODER_2X4_STR_COMB_OUT_EN
  ,
  output logic [0:3] z_comb,
  output logic       err
`endif
);

  localparam logic [0:3] C_POL_MASK = {4{OUT_ACT_LOW}};

  // Gate-level decode, active-high form.
  wire w_na;
  wire w_nb;
  wire w_d0;
  wire w_d1;
  wire w_d2;
  wire w_d3;

  not u_not_a (w_na, a);
  not u_not_b (w_nb, b);

  and u_and_d0 (w_d0, w_na, w_nb, en);
  and u_and_d1 (w_d1, w_na, b,    en);
  and u_and_d2 (w_d2, a,    w_nb, en);
  and u_and_d3 (w_d3, a,    b,    en);

  logic [0:3] w_dec;
  logic [0:3] z_d;
  logic [0:3] z_q;
  logic       vld_q;

  assign w_dec = {w_d0, w_d1, w_d2, w_d3};

  // The polarity is applied ahead of the register, so the flops hold the
  // final output levels.
  assign z_d = w_dec ^ C_POL_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= C_POL_MASK;
      vld_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      vld_q <= en;
    end
  end

  assign z   = z_q;
  assign vld = vld_q;

`ifdef DECODER_2X4_STR_COMB_OUT_EN
  logic w_onehot;
  logic err_d;
  logic err_q;
  logic [0:3] w_z_hi;

  // The one-hot check runs on the next-state values in active-high form. That
  // way err lines up in time with the z/vld pair that it describes.
  assign w_z_hi   = z_d ^ C_POL_MASK;
  assign w_onehot = (w_z_hi == 4'b1000) || (w_z_hi == 4'b0100) ||
                    (w_z_hi == 4'b0010) || (w_z_hi == 4'b0001);
  assign err_d    = en & ~w_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign z_comb = z_d;
  assign err    = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_2x4_str.sv
`default_nettype none
module tb_decoder_2x4_str;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic       en  = 1'b0;
  logic [0:3] z_h;
  logic       vld_h;
  logic [0:3] z_l;
  logic       vld_l;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decoder_2x4_str #(.OUT_ACT_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .z(z_h), .vld(vld_h)
  );

  decoder_2x4_str #(.OUT_ACT_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .z(z_l), .vld(vld_l)
  );

  // Model: the selected line is index 2*a+b, counted from the left of the
  // [0:3] bus, so the active-high word is 4'b1000 shifted right by that index.
  logic [3:0] m_z;
  logic       m_vld;
  logic       m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_z     <= 4'b0000;
      m_vld   <= 1'b0;
      m_known <= 1'b1;
    end else begin
      m_z     <= en ? (4'b1000 >> (2 * int'(a) + int'(b))) : 4'b0000;
      m_vld   <= en;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  // Continuous comparison against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (m_known) begin
      chk("model_z_hi",   z_h,          m_z);
      chk("model_vld_hi", {3'b0, vld_h}, {3'b0, m_vld});
      chk("model_z_lo",   z_l,          ~m_z);
      chk("model_vld_lo", {3'b0, vld_l}, {3'b0, m_vld});
    end
  end

  // Drive one input vector on a falling edge, then wait until the falling edge
  // after the next rising edge, when the registered result is visible.
  task automatic step(input logic r, input logic ia, input logic ib, input logic ie);
    @(negedge clk);
    rst = r; a = ia; b = ib; en = ie;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held for two cycles with every input high.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_z",     z_h, 4'b0000);
    chk("rst_vld",   {3'b0, vld_h}, 4'b0000);
    chk("rst_z_lo",  z_l, 4'b1111);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst2_z",    z_h, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rel_z",     z_h, 4'b0001);
    chk("rel_vld",   {3'b0, vld_h}, 4'b0001);

    // Enabled sweep.
    step(1'b0, 1'b0, 1'b0, 1'b1); chk("sweep00", z_h, 4'b1000);
    step(1'b0, 1'b0, 1'b1, 1'b1); chk("sweep01", z_h, 4'b0100);
    chk("lo01",   z_l, 4'b1011);
    step(1'b0, 1'b1, 1'b0, 1'b1); chk("sweep10", z_h, 4'b0010);
    step(1'b0, 1'b1, 1'b1, 1'b1); chk("sweep11", z_h, 4'b0001);
    chk("sweep_vld", {3'b0, vld_h}, 4'b0001);

    // Disabled.
    step(1'b0, 1'b0, 1'b0, 1'b0); chk("dis00", z_h, 4'b0000);
    chk("dis00_vld", {3'b0, vld_h}, 4'b0000);
    chk("dis_lo",    z_l, 4'b1111);
    step(1'b0, 1'b0, 1'b1, 1'b0); chk("dis01", z_h, 4'b0000);

    // Mid-stream reset, pulsed for one cycle while {a,b}=10.
    step(1'b0, 1'b0, 1'b0, 1'b1); chk("ms00", z_h, 4'b1000);
    step(1'b0, 1'b0, 1'b1, 1'b1); chk("ms01", z_h, 4'b0100);
    step(1'b1, 1'b1, 1'b0, 1'b1); chk("ms_rst", z_h, 4'b0000);
    chk("ms_rst_vld", {3'b0, vld_h}, 4'b0000);
    chk("ms_rst_lo",  z_l, 4'b1111);
    step(1'b0, 1'b1, 1'b0, 1'b1); chk("ms_resume", z_h, 4'b0010);
    step(1'b0, 1'b1, 1'b1, 1'b1); chk("ms11", z_h, 4'b0001);

    // Random vectors, checked only by the model.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_2x4_str.md
Name: decoder_2x4_str

Overview:
- 2-to-4 line decoder with active-high enable, built structurally from gate primitives (NOT/AND), with a registered output stage.
- Select inputs a (MSB) and b (LSB) drive exactly one of four outputs high when enabled.
- Used as a small address/chip-select decoder in synchronous datapaths. The output register gives a clean, glitch-free select bus.

Parameters:
- OUT_ACT_LOW, 0, when 1 every z bit is inverted at the register input, giving active-low selects. The reset value is inverted to match.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a    input  1  select MSB
- b    input  1  select LSB
- en   input  1  decode enable, active high
- z    output 4  decoded select bus, declared [0:3], so z[0] is the leftmost bit; registered
- vld  output 1  registered copy of en; marks a cycle in which z carries a decoded select

Behaviour:
- Combinational decode, gate level, active-high form:
  - d0 = ~a & ~b & en
  - d1 = ~a & b & en
  - d2 = a & ~b & en
  - d3 = a & b & en
- Index mapping: {a,b} = 00 selects z[0]; 01 selects z[1]; 10 selects z[2]; 11 selects z[3].
- en = 0 forces d0..d3 = 0 regardless of a and b.
- Register update on each rising clk edge:
  - rst = 1: z <= 4'b0000 and vld <= 0. With OUT_ACT_LOW = 1, z <= 4'b1111 instead.
  - rst = 0: z[i] <= d[i] (XOR OUT_ACT_LOW) and vld <= en.
- Latency: exactly 1 clock from a/b/en to z/vld. There is no combinational path from inputs to outputs in the default build.
- Reset is synchronous and takes priority over the inputs. Asserting rst mid-stream clears the outputs at the next edge. The first decode after rst is released appears one edge after release.
- One-hot invariant, active-high form: when vld = 1, exactly one z bit is 1. When vld = 0, all z bits are 0.
- X/Z on a, b or en propagates per gate semantics. No X-masking is added.
- No internal state other than the 5 output flops.

Optional Feature:
- Macro: DECODER_2X4_STR_COMB_OUT_EN
- Defined:
  - Adds output port z_comb [0:3], driven directly by d0..d3 after the OUT_ACT_LOW inversion, with zero latency and no reset.
  - Adds a registered output port err, 1 bit. err is set when vld = 1 and z is not one-hot. It is cleared by rst and recomputes every cycle.
- Not defined: neither port exists. Only z and vld are present.

Test Plan:
- Reset: rst = 1 for 2 cycles with a = 1, b = 1, en = 1 -> z = 0000 and vld = 0 after the first edge. Release rst -> z = 0001 (z[3] = 1) one edge later.
- Enabled sweep, one step per cycle, {a,b} = 00, 01, 10, 11 with en = 1 -> the cycle after each step gives z[0..3] = 1000, 0100, 0010, 0001 respectively, with vld = 1.
- Disabled: en = 0 with {a,b} = 00, then 01 -> z = 0000 and vld = 0 one cycle later for both.
- Mid-stream reset: run the sweep and pulse rst for 1 cycle at {a,b} = 10 -> z = 0000 on that edge. The next edge resumes the correct decode of the current inputs.
- OUT_ACT_LOW = 1 build: {a,b} = 01, en = 1 -> z = 1011. en = 0 -> z = 1111. Reset -> z = 1111.
- With DECODER_2X4_STR_COMB_OUT_EN defined: change the inputs mid-cycle -> z_comb updates in the same cycle, while z updates at the next edge. err stays 0 through the full sweep.
